// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: mem-wait > taken branch > load-use.
// Optional perf counters (o_stall_cnt/o_flush_cnt) under PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  input  logic [4:0] i_ex_rt,
  input  logic       i_ex_mem_read,
  input  logic       i_branch_taken,
  input  logic       i_mem_req,
  input  logic       i_mem_ready,
  output logic       o_pc_en,
  output logic       o_ifid_en,
  output logic       o_ifid_flush,
  output logic       o_idex_en,
  output logic       o_idex_flush,
  output logic       o_exmem_en,
  output logic       o_memwb_en,
  output logic       o_memwb_bubble,
  output logic [1:0] o_state
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_UNUSED     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CS_NORMAL,
    CS_FREEZE,
    CS_BRFLUSH,
    CS_LDSTALL
  } ctl_set_e;

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctl_set_e         cset;
  logic             hz, mw, eval_run;

  assign hz = i_ex_mem_read && (i_ex_rt != 5'd0) &&
              ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
  assign mw = i_mem_req && !i_mem_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cset     = CS_NORMAL;
    eval_run = 1'b0;
    case (state_q)
      ST_LOAD_STALL: begin
        if (mw) begin
          cset    = CS_FREEZE;
          state_d = ST_MEM_WAIT;
        end else begin
          cset    = CS_LDSTALL;
          if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
          state_d = (cnt_q > CNT_ONE) ? ST_LOAD_STALL : ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mw) begin
          cset = CS_FREEZE;
        end else if (cnt_q != '0) begin
          // resume a load stall that the memory wait interrupted
          cset    = CS_LDSTALL;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q > CNT_ONE) ? ST_LOAD_STALL : ST_RUN;
        end else begin
          eval_run = 1'b1;
        end
      end
      default: begin
        if (mw) begin
          cset    = CS_FREEZE;
          state_d = ST_MEM_WAIT;
        end else begin
          eval_run = 1'b1;
        end
      end
    endcase

    // branch beats load-use: the dependent ID instruction is being discarded anyway
    if (eval_run) begin
      state_d = ST_RUN;
      if (i_branch_taken) begin
        cset = CS_BRFLUSH;
      end else if (hz) begin
        cset    = CS_LDSTALL;
        cnt_d   = LOAD_CNT;
        state_d = (LOAD_STALL_CYCLES > 1) ? ST_LOAD_STALL : ST_RUN;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    o_pc_en        = 1'b0;
    o_ifid_en      = 1'b0;
    o_ifid_flush   = 1'b0;
    o_idex_en      = 1'b0;
    o_idex_flush   = 1'b0;
    o_exmem_en     = 1'b0;
    o_memwb_en     = 1'b0;
    o_memwb_bubble = 1'b0;
    if (i_rst_n) begin
      case (cset)
        CS_FREEZE: begin
          o_memwb_en     = 1'b1;
          o_memwb_bubble = 1'b1;
        end
        CS_BRFLUSH: begin
          o_pc_en      = 1'b1;
          o_ifid_en    = 1'b1;
          o_ifid_flush = 1'b1;
          o_idex_en    = 1'b1;
          o_idex_flush = 1'b1;
          o_exmem_en   = 1'b1;
          o_memwb_en   = 1'b1;
        end
        CS_LDSTALL: begin
          o_idex_en    = 1'b1;
          o_idex_flush = 1'b1;
          o_exmem_en   = 1'b1;
          o_memwb_en   = 1'b1;
        end
        default: begin
          o_pc_en    = 1'b1;
          o_ifid_en  = 1'b1;
          o_idex_en  = 1'b1;
          o_exmem_en = 1'b1;
          o_memwb_en = 1'b1;
        end
      endcase
    end
  end

  assign o_state = state_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!o_pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (o_ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: two instances (1 and 3 load-stall cycles) share stimulus; control
// outputs are packed as {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_bubble}.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] NRM = 8'b1101_0110;
  localparam logic [7:0] FRZ = 8'b0000_0011;
  localparam logic [7:0] BRF = 8'b1111_1110;
  localparam logic [7:0] LDS = 8'b0001_1110;
  localparam logic [7:0] OFF = 8'b0000_0000;

  logic       i_clk, i_rst_n;
  logic [4:0] i_id_rs, i_id_rt, i_ex_rt;
  logic       i_id_uses_rt, i_ex_mem_read, i_branch_taken, i_mem_req, i_mem_ready;

  logic pc1, ifen1, iffl1, iden1, idfl1, exen1, wben1, wbb1;
  logic pc3, ifen3, iffl3, iden3, idfl3, exen3, wben3, wbb3;
  logic [1:0] st1, st3;
  logic [7:0] ctl1, ctl3;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] sc1, fc1, sc3, fc3;
`endif

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(3)) u1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_uses_rt(i_id_uses_rt), .i_ex_rt(i_ex_rt), .i_ex_mem_read(i_ex_mem_read),
    .i_branch_taken(i_branch_taken), .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready),
    .o_pc_en(pc1), .o_ifid_en(ifen1), .o_ifid_flush(iffl1), .o_idex_en(iden1),
    .o_idex_flush(idfl1), .o_exmem_en(exen1), .o_memwb_en(wben1), .o_memwb_bubble(wbb1),
    .o_state(st1)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , .o_stall_cnt(sc1), .o_flush_cnt(fc1)
`endif
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(3)) u3 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_uses_rt(i_id_uses_rt), .i_ex_rt(i_ex_rt), .i_ex_mem_read(i_ex_mem_read),
    .i_branch_taken(i_branch_taken), .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready),
    .o_pc_en(pc3), .o_ifid_en(ifen3), .o_ifid_flush(iffl3), .o_idex_en(iden3),
    .o_idex_flush(idfl3), .o_exmem_en(exen3), .o_memwb_en(wben3), .o_memwb_bubble(wbb3),
    .o_state(st3)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , .o_stall_cnt(sc3), .o_flush_cnt(fc3)
`endif
  );

  assign ctl1 = {pc1, ifen1, iffl1, iden1, idfl1, exen1, wben1, wbb1};
  assign ctl3 = {pc3, ifen3, iffl3, iden3, idfl3, exen3, wben3, wbb3};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic drive(input int rs, input int rt, input int urt, input int ert,
                       input int mrd, input int br, input int req, input int rdy);
    i_id_rs        = 5'(rs);
    i_id_rt        = 5'(rt);
    i_id_uses_rt   = (urt != 0);
    i_ex_rt        = 5'(ert);
    i_ex_mem_read  = (mrd != 0);
    i_branch_taken = (br != 0);
    i_mem_req      = (req != 0);
    i_mem_ready    = (rdy != 0);
  endtask

  task automatic quiet();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // inputs change 1 time unit after the rising edge, outputs are sampled 2 units later
  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    quiet();
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (ctl1 !== OFF || st1 !== 2'd0) begin
        errors++;
        $display("FAIL reset[%0d] u1 got ctl=%b st=%0d exp ctl=%b st=0", c, ctl1, st1, OFF);
      end
      checks++;
      if (ctl3 !== OFF || st3 !== 2'd0) begin
        errors++;
        $display("FAIL reset[%0d] u3 got ctl=%b st=%0d exp ctl=%b st=0", c, ctl3, st3, OFF);
      end
      next_cyc();
    end
    i_rst_n = 1'b1;
    next_cyc();
    #2;
    checks++;
    if (ctl1 !== NRM || st1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_release u1 got ctl=%b st=%0d exp ctl=%b st=0", ctl1, st1, NRM);
    end
    checks++;
    if (ctl3 !== NRM || st3 !== 2'd0) begin
      errors++;
      $display("FAIL reset_release u3 got ctl=%b st=%0d exp ctl=%b st=0", ctl3, st3, NRM);
    end
    next_cyc();
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 9; c++) begin
      logic [7:0] e1, e3;
      logic [1:0] s1, s3;
      quiet();
      e1 = NRM; s1 = 2'd0; e3 = NRM; s3 = 2'd0;
      case (c)
        0: drive(0, 0, 0, 0, 1, 0, 0, 0);   // r0 destination never hazards
        1: begin drive(5, 0, 0, 5, 1, 0, 0, 0); e1 = LDS; e3 = LDS; end
        2: begin e3 = LDS; s3 = 2'd1; end
        3: begin e3 = LDS; s3 = 2'd1; end
        4: drive(3, 7, 0, 7, 1, 0, 0, 0);   // rt match ignored when rt unused
        5: begin drive(3, 7, 1, 7, 1, 0, 0, 0); e1 = LDS; e3 = LDS; end
        6: begin e3 = LDS; s3 = 2'd1; end
        7: begin e3 = LDS; s3 = 2'd1; end
        default: ;
      endcase
      #2;
      checks++;
      if (ctl1 !== e1 || st1 !== s1) begin
        errors++;
        $display("FAIL load_use[%0d] u1 got ctl=%b st=%0d exp ctl=%b st=%0d", c, ctl1, st1, e1, s1);
      end
      checks++;
      if (ctl3 !== e3 || st3 !== s3) begin
        errors++;
        $display("FAIL load_use[%0d] u3 got ctl=%b st=%0d exp ctl=%b st=%0d", c, ctl3, st3, e3, s3);
      end
      next_cyc();
    end
  endtask

  // hazard held through the stall and a branch in its last cycle: both ignored by u3
  task automatic test_load_stall3();
    logic [7:0] e1 [4] = '{LDS, LDS, BRF, NRM};
    logic [7:0] e3 [4] = '{LDS, LDS, LDS, NRM};
    logic [1:0] s3 [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
    for (int c = 0; c < 4; c++) begin
      case (c)
        0, 1: drive(5, 0, 0, 5, 1, 0, 0, 0);
        2: drive(5, 0, 0, 5, 1, 1, 0, 0);
        default: quiet();
      endcase
      #2;
      checks++;
      if (ctl3 !== e3[c] || st3 !== s3[c]) begin
        errors++;
        $display("FAIL load_stall3[%0d] u3 got ctl=%b st=%0d exp ctl=%b st=%0d", c, ctl3, st3, e3[c], s3[c]);
      end
      checks++;
      if (ctl1 !== e1[c] || st1 !== 2'd0) begin
        errors++;
        $display("FAIL load_stall3[%0d] u1 got ctl=%b st=%0d exp ctl=%b st=0", c, ctl1, st1, e1[c]);
      end
      next_cyc();
    end
  endtask

  task automatic test_mem_wait();
    logic [7:0] e1 [14] = '{FRZ, FRZ, FRZ, FRZ, NRM, NRM, FRZ, BRF, NRM, FRZ, LDS, NRM, NRM, NRM};
    logic [1:0] s1 [14] = '{0, 2, 2, 2, 2, 0, 0, 2, 0, 0, 2, 0, 0, 0};
    logic [7:0] e3 [14] = '{FRZ, FRZ, FRZ, FRZ, NRM, NRM, FRZ, BRF, NRM, FRZ, LDS, LDS, LDS, NRM};
    logic [1:0] s3 [14] = '{0, 2, 2, 2, 2, 0, 0, 2, 0, 0, 2, 1, 1, 0};
    for (int c = 0; c < 14; c++) begin
      case (c)
        0, 1, 3, 6, 9: drive(0, 0, 0, 0, 0, 0, 1, 0);
        2: drive(5, 0, 0, 5, 1, 1, 1, 0);    // branch and hazard ignored while waiting
        4: drive(0, 0, 0, 0, 0, 0, 1, 1);
        7: drive(5, 0, 0, 5, 1, 1, 1, 1);    // exit cycle: branch wins over hazard
        10: drive(5, 0, 0, 5, 1, 0, 1, 1);   // exit cycle: load-use starts a fresh stall
        default: quiet();
      endcase
      #2;
      checks++;
      if (ctl1 !== e1[c] || st1 !== s1[c]) begin
        errors++;
        $display("FAIL mem_wait[%0d] u1 got ctl=%b st=%0d exp ctl=%b st=%0d", c, ctl1, st1, e1[c], s1[c]);
      end
      checks++;
      if (ctl3 !== e3[c] || st3 !== s3[c]) begin
        errors++;
        $display("FAIL mem_wait[%0d] u3 got ctl=%b st=%0d exp ctl=%b st=%0d", c, ctl3, st3, e3[c], s3[c]);
      end
      next_cyc();
    end
  endtask

  task automatic test_branch_priority();
    logic [7:0] e [5] = '{BRF, NRM, FRZ, NRM, NRM};
    logic [1:0] s [5] = '{0, 0, 0, 2, 0};
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(5, 0, 0, 5, 1, 1, 0, 0);
        2: drive(5, 0, 0, 5, 1, 1, 1, 0);
        3: drive(0, 0, 0, 0, 0, 0, 1, 1);
        default: quiet();
      endcase
      #2;
      checks++;
      if (ctl1 !== e[c] || st1 !== s[c]) begin
        errors++;
        $display("FAIL branch_prio[%0d] u1 got ctl=%b st=%0d exp ctl=%b st=%0d", c, ctl1, st1, e[c], s[c]);
      end
      checks++;
      if (ctl3 !== e[c] || st3 !== s[c]) begin
        errors++;
        $display("FAIL branch_prio[%0d] u3 got ctl=%b st=%0d exp ctl=%b st=%0d", c, ctl3, st3, e[c], s[c]);
      end
      next_cyc();
    end
  endtask

  // memory wait arrives while one load-stall cycle remains in u3
  task automatic test_stall_then_wait();
    logic [7:0] e1 [6] = '{LDS, NRM, FRZ, FRZ, NRM, NRM};
    logic [1:0] s1 [6] = '{0, 0, 0, 2, 2, 0};
    logic [7:0] e3 [6] = '{LDS, LDS, FRZ, FRZ, LDS, NRM};
    logic [1:0] s3 [6] = '{0, 1, 1, 2, 2, 0};
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(5, 0, 0, 5, 1, 0, 0, 0);
        2, 3: drive(0, 0, 0, 0, 0, 0, 1, 0);
        4: drive(0, 0, 0, 0, 0, 0, 1, 1);
        default: quiet();
      endcase
      #2;
      checks++;
      if (ctl1 !== e1[c] || st1 !== s1[c]) begin
        errors++;
        $display("FAIL stall_wait[%0d] u1 got ctl=%b st=%0d exp ctl=%b st=%0d", c, ctl1, st1, e1[c], s1[c]);
      end
      checks++;
      if (ctl3 !== e3[c] || st3 !== s3[c]) begin
        errors++;
        $display("FAIL stall_wait[%0d] u3 got ctl=%b st=%0d exp ctl=%b st=%0d", c, ctl3, st3, e3[c], s3[c]);
      end
      next_cyc();
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    next_cyc();
    #2;
    checks++;
    if (st3 !== 2'd2 || ctl3 !== FRZ) begin
      errors++;
      $display("FAIL rst_mid_wait_pre u3 got ctl=%b st=%0d exp ctl=%b st=2", ctl3, st3, FRZ);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (st3 !== 2'd0 || ctl3 !== OFF || st1 !== 2'd0 || ctl1 !== OFF) begin
      errors++;
      $display("FAIL rst_mid_wait got u1 ctl=%b st=%0d u3 ctl=%b st=%0d exp ctl=%b st=0",
               ctl1, st1, ctl3, st3, OFF);
    end
`ifdef PIPE_HAZARD_PERF_CNT_EN
    checks++;
    if (sc1 !== 32'd0 || fc1 !== 32'd0 || sc3 !== 32'd0 || fc3 !== 32'd0) begin
      errors++;
      $display("FAIL rst_perf got %0d %0d %0d %0d exp all 0", sc1, fc1, sc3, fc3);
    end
`endif
    next_cyc();
    #2;
    checks++;
    if (st3 !== 2'd0 || ctl3 !== OFF) begin
      errors++;
      $display("FAIL rst_hold u3 got ctl=%b st=%0d exp ctl=%b st=0", ctl3, st3, OFF);
    end
    quiet();
    i_rst_n = 1'b1;
    #1;
    checks++;
    if (st3 !== 2'd0 || ctl3 !== NRM || ctl1 !== NRM) begin
      errors++;
      $display("FAIL rst_release2 got u1 ctl=%b u3 ctl=%b st=%0d exp ctl=%b st=0", ctl1, ctl3, st3, NRM);
    end
    next_cyc();
  endtask

`ifdef PIPE_HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    for (int c = 0; c < 4; c++) begin
      case (c)
        1: drive(0, 0, 0, 0, 0, 1, 0, 0);
        2: drive(0, 0, 0, 0, 0, 0, 1, 0);
        3: drive(0, 0, 0, 0, 0, 0, 1, 1);
        default: quiet();
      endcase
      next_cyc();
    end
    quiet();
    #2;
    checks++;
    if (sc1 !== 32'd1 || fc1 !== 32'd1 || sc3 !== 32'd1 || fc3 !== 32'd1) begin
      errors++;
      $display("FAIL perf_cnt got stall=%0d/%0d flush=%0d/%0d exp 1/1 1/1", sc1, sc3, fc1, fc3);
    end
    next_cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_load_stall3();
    test_mem_wait();
    test_branch_priority();
    test_stall_then_wait();
    test_reset_mid_wait();
`ifdef PIPE_HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
